roach_clk_sequencer: RTL and testbench
======================================

ROACH_CLK_SEQUENCER -- requirements
Module: roach_clk_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, 16, idelay_rst assertion length in cycles (>=2).
REQ-002 SHALL have parameter LOCK_TIMEOUT, 65535, cycles to wait for clock lock per attempt.
REQ-003 SHALL have parameter RDY_TIMEOUT, 4096, cycles to wait for idelay_rdy per attempt.
REQ-004 SHALL have parameter HOLD_CYCLES, 32, cycles sys_rst is held after idelay_rdy before release.
REQ-005 SHALL have parameter MAX_RETRIES, 3, failed attempts tolerated before FAULT.
REQ-006 SHALL have port sys_clk  input  1  sole clock; all logic rising-edge.
REQ-007 SHALL have port sys_rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port sys_clk_lock  input  1  clock-generator lock, asynchronous to sys_clk.
REQ-009 SHALL have port idelay_rdy  input  1  IDELAYCTRL ready, asynchronous to sys_clk.
REQ-010 SHALL have port soft_rst_req  input  1  single-cycle software restart request.
REQ-011 SHALL have port idelay_rst  output  1  reset to the IDELAY controller.
REQ-012 SHALL have port sys_rst  output  1  active-high synchronous reset for user logic.
REQ-013 SHALL have port ready  output  1  high only in RUN.
REQ-014 SHALL have port fault  output  1  high only in FAULT.
REQ-015 SHALL have port state  output  3  current state encoding.
REQ-016 SHALL have port retry_cnt  output  2  failed attempts in current sequence.
REQ-017 SHALL have port lock_loss_cnt  output  8  saturating count of lock losses while in RUN.

Function
REQ-018 SHALL synchronise sys_clk_lock and idelay_rdy through two flops each (lock_s, rdy_s); decisions use only synchronised values (2-cycle input latency).
REQ-019 SHALL implement states WAIT_LOCK=0, IDLY_RST=1, WAIT_RDY=2, HOLD=3, RUN=4, FAULT=5; one shared 16-bit down-counter times every state.
REQ-020 WAIT_LOCK: idelay_rst=1, sys_rst=1; lock_s=1 -> IDLY_RST loaded with RST_PULSE_CYCLES; counter expiry -> failure (REQ-025).
REQ-021 IDLY_RST: idelay_rst=1 exactly RST_PULSE_CYCLES cycles, then WAIT_RDY; lock_s=0 -> WAIT_LOCK, no retry charged.
REQ-022 WAIT_RDY: idelay_rst=0; rdy_s=1 -> HOLD; expiry of RDY_TIMEOUT -> failure; lock_s=0 -> WAIT_LOCK.
REQ-023 HOLD: sys_rst=1 for HOLD_CYCLES cycles then RUN; lock_s=0 or rdy_s=0 -> WAIT_LOCK.
REQ-024 RUN: sys_rst=0, idelay_rst=0, ready=1, retry_cnt cleared on entry; lock_s=0 -> WAIT_LOCK and lock_loss_cnt+1 (saturate at 255); rdy_s=0 -> IDLY_RST.
REQ-025 Failure: if retry_cnt==MAX_RETRIES -> FAULT, else retry_cnt+1 and -> WAIT_LOCK with counter reloaded.
REQ-026 FAULT: idelay_rst=1, sys_rst=1, fault=1; left only via soft_rst_req or sys_rst_n.
REQ-027 soft_rst_req in any state -> WAIT_LOCK next cycle, retry_cnt cleared; lock_loss_cnt unchanged; takes priority over all simultaneous events.
REQ-028 Simultaneous lock loss and counter expiry SHALL be treated as lock loss (no retry charged).
REQ-029 sys_rst and idelay_rst SHALL be registered outputs, glitch-free.

Reset
REQ-030 On sys_rst_n=0: state=WAIT_LOCK, idelay_rst=1, sys_rst=1, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, counter=LOCK_TIMEOUT, synchronisers=0.
REQ-031 Reset assertion SHALL take effect asynchronously mid-sequence; deassertion is assumed synchronous to sys_clk upstream.

Structure
REQ-032 State encodings and default parameter constants SHALL live in shared package roach_infra_pkg.
REQ-033 Two-flop synchroniser SHALL be sub-module roach_sync2, instantiated twice.

Verification
REQ-034 Lock at cycle 10, rdy 5 cycles after idelay_rst falls -> idelay_rst high 16 cycles post-lock_s, ready=1 exactly 32 cycles after rdy_s.
REQ-035 idelay_rdy never rises, RDY_TIMEOUT=100 -> retry_cnt 1,2,3 then fault=1, state=5, sys_rst=1.
REQ-036 Drop sys_clk_lock in RUN 3 times -> lock_loss_cnt=3, sys_rst=1 within 3 cycles of each drop, full re-sequence each time.
REQ-037 soft_rst_req in FAULT -> state=0, retry_cnt=0, fault=0 next cycle; normal lock -> RUN.
REQ-038 sys_rst_n pulsed low during HOLD -> all outputs at reset values immediately, no ready glitch.
REQ-039 Lock loss on same cycle as LOCK_TIMEOUT expiry -> retry_cnt unchanged.

Source files
------------

// File: rtl/roach_infra_pkg.sv
// Purpose : shared constants for the ROACH clock/reset infrastructure.
// Latency : n/a (package only).
// Backpr. : n/a. Holds state encodings, counter width and default timings.
package roach_infra_pkg;

    localparam int CNT_W = 16;

    // Sequencer state encodings; these values are visible on the state port.
    localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] ST_IDLY_RST  = 3'd1;
    localparam logic [2:0] ST_WAIT_RDY  = 3'd2;
    localparam logic [2:0] ST_HOLD      = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;
    localparam logic [2:0] ST_FAULT     = 3'd5;

    localparam int DEF_RST_PULSE_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT     = 65535;
    localparam int DEF_RDY_TIMEOUT      = 4096;
    localparam int DEF_HOLD_CYCLES      = 32;
    localparam int DEF_MAX_RETRIES      = 3;

endpackage

// File: rtl/roach_sync2.sv
// Purpose : two-flop synchroniser for a single asynchronous level.
// Latency : 2 clk_i cycles from d_i to q_o.
// Backpr. : none. Ports: clk_i, rst_ni (async active-low), d_i (async level), q_o (synchronised).
module roach_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/roach_clk_sequencer.sv
// Purpose : power-up sequencer: wait for clock lock, pulse idelay_rst, wait idelay_rdy, hold then release sys_rst.
// Latency : inputs seen 2 cycles late through synchronisers; state and all outputs registered.
// Backpr. : none. Inputs sys_clk/sys_rst_n/sys_clk_lock/idelay_rdy/soft_rst_req; outputs idelay_rst, sys_rst, ready, fault, state, retry_cnt, lock_loss_cnt.
module roach_clk_sequencer
    import roach_infra_pkg::*;
#(
    parameter int RST_PULSE_CYCLES = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT     = DEF_LOCK_TIMEOUT,
    parameter int RDY_TIMEOUT      = DEF_RDY_TIMEOUT,
    parameter int HOLD_CYCLES      = DEF_HOLD_CYCLES,
    parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       sys_clk_lock,
    input  logic       idelay_rdy,
    input  logic       soft_rst_req,
    output logic       idelay_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [CNT_W-1:0] LOCK_LOAD  = 16'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] PULSE_LOAD = 16'(RST_PULSE_CYCLES);
    localparam logic [CNT_W-1:0] RDY_LOAD   = 16'(RDY_TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = 16'(HOLD_CYCLES);
    localparam logic [1:0]       MAX_RETRY  = 2'(MAX_RETRIES);

    logic             lock_s;
    logic             rdy_s;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [7:0]       llc_q, llc_d;
    logic             idelay_rst_q, sys_rst_q, ready_q, fault_q;
    logic             expired;
    logic             fail;

    roach_sync2 u_sync_lock (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .d_i    (sys_clk_lock),
        .q_o    (lock_s)
    );

    roach_sync2 u_sync_rdy (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .d_i    (idelay_rdy),
        .q_o    (rdy_s)
    );

    // A state loaded with N expires on its N-th cycle, so it lasts exactly N cycles.
    assign expired = (cnt_q <= 16'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        llc_d   = llc_q;
        fail    = 1'b0;
        if (soft_rst_req) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = LOCK_LOAD;
            retry_d = 2'd0;
        end else begin
            // Lock loss is tested before expiry so a coincident timeout is never charged as a retry.
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_IDLY_RST;
                        cnt_d   = PULSE_LOAD;
                    end else if (expired) begin
                        fail = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_IDLY_RST: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = LOCK_LOAD;
                    end else if (expired) begin
                        state_d = ST_WAIT_RDY;
                        cnt_d   = RDY_LOAD;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_WAIT_RDY: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = LOCK_LOAD;
                    end else if (rdy_s) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else if (expired) begin
                        fail = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (!lock_s || !rdy_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = LOCK_LOAD;
                    end else if (expired) begin
                        state_d = ST_RUN;
                        retry_d = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = LOCK_LOAD;
                        if (llc_q != 8'hFF) begin
                            llc_d = llc_q + 8'd1;
                        end
                    end else if (!rdy_s) begin
                        state_d = ST_IDLY_RST;
                        cnt_d   = PULSE_LOAD;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    // Unused encodings recover through a fresh lock sequence.
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = LOCK_LOAD;
                end
            endcase

            if (fail) begin
                if (retry_q == MAX_RETRY) begin
                    state_d = ST_FAULT;
                end else begin
                    retry_d = retry_q + 2'd1;
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = LOCK_LOAD;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= LOCK_LOAD;
            retry_q <= 2'd0;
            llc_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            llc_q   <= llc_d;
        end
    end

    // Outputs decoded from the next state and registered, so they switch
    // together with state and cannot glitch.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idelay_rst_q <= 1'b1;
            sys_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            idelay_rst_q <= (state_d == ST_WAIT_LOCK) || (state_d == ST_IDLY_RST) ||
                            (state_d == ST_FAULT);
            sys_rst_q    <= (state_d != ST_RUN);
            ready_q      <= (state_d == ST_RUN);
            fault_q      <= (state_d == ST_FAULT);
        end
    end

    assign idelay_rst    = idelay_rst_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign state         = state_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_roach_clk_sequencer.sv
// Purpose : self-checking bench for roach_clk_sequencer with a phase/elapsed-time reference model.
// Latency : model compared against DUT outputs every cycle on the falling edge.
// Backpr. : none; directed scenarios followed by a randomized lock/rdy/soft-restart phase.
module tb_roach_clk_sequencer;

    localparam int RP = 16;
    localparam int LT = 200;
    localparam int RT = 100;
    localparam int HC = 32;
    localparam int MR = 3;

    logic       sys_clk      = 1'b0;
    logic       sys_rst_n    = 1'b1;
    logic       sys_clk_lock = 1'b0;
    logic       idelay_rdy   = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       idelay_rst, sys_rst, ready, fault;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0..5, cycles already spent in the phase,
    // retries, lock losses, and two-deep delay lines standing in for the synchronisers.
    int m_ph, m_el, m_rc, m_llc;
    bit lq[$];
    bit rq[$];

    always #5 sys_clk = ~sys_clk;

    roach_clk_sequencer #(
        .RST_PULSE_CYCLES (RP),
        .LOCK_TIMEOUT     (LT),
        .RDY_TIMEOUT      (RT),
        .HOLD_CYCLES      (HC),
        .MAX_RETRIES      (MR)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .sys_clk_lock  (sys_clk_lock),
        .idelay_rdy    (idelay_rdy),
        .soft_rst_req  (soft_rst_req),
        .idelay_rst    (idelay_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .fault         (fault),
        .state         (state),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {15'd0, state, retry_cnt, lock_loss_cnt, ready, fault, sys_rst, idelay_rst};
    endfunction

    function automatic logic [31:0] model_vec();
        logic rdy_e, flt_e, srst_e, irst_e;
        rdy_e  = (m_ph == 4);
        flt_e  = (m_ph == 5);
        srst_e = (m_ph != 4);
        irst_e = (m_ph == 0) || (m_ph == 1) || (m_ph == 5);
        return {15'd0, 3'(m_ph), 2'(m_rc), 8'(m_llc), rdy_e, flt_e, srst_e, irst_e};
    endfunction

    task automatic model_reset();
        m_ph  = 0;
        m_el  = 0;
        m_rc  = 0;
        m_llc = 0;
        lq = '{1'b0, 1'b0};
        rq = '{1'b0, 1'b0};
    endtask

    task automatic go(input int p);
        m_ph = p;
        m_el = 0;
    endtask

    task automatic model_step();
        bit ls, rs, failed;
        ls = lq[0];
        rs = rq[0];
        void'(lq.pop_front());
        void'(rq.pop_front());
        lq.push_back(sys_clk_lock);
        rq.push_back(idelay_rdy);
        failed = 1'b0;
        if (soft_rst_req) begin
            go(0);
            m_rc = 0;
        end else begin
            case (m_ph)
                0: if (ls) go(1); else if (m_el == LT - 1) failed = 1'b1; else m_el++;
                1: if (!ls) go(0); else if (m_el == RP - 1) go(2); else m_el++;
                2: if (!ls) go(0); else if (rs) go(3); else if (m_el == RT - 1) failed = 1'b1; else m_el++;
                3: if (!ls || !rs) go(0);
                   else if (m_el == HC - 1) begin go(4); m_rc = 0; end
                   else m_el++;
                4: if (!ls) begin go(0); if (m_llc < 255) m_llc++; end
                   else if (!rs) go(1);
                default: ;
            endcase
            if (failed) begin
                if (m_rc == MR) go(5);
                else begin m_rc++; go(0); end
            end
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        chk("outs", dut_vec(), model_vec());
    endtask

    task automatic run_until(input int s, input int max, input string tag);
        int n;
        n = 0;
        while (state !== 3'(s) && n < max) begin
            tick();
            n++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_idelay_rst"}, 32'(idelay_rst), 1);
        chk({tag, "_sys_rst"}, 32'(sys_rst), 1);
        chk({tag, "_ready"}, 32'(ready), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
        chk({tag, "_retry"}, 32'(retry_cnt), 0);
        chk({tag, "_llc"}, 32'(lock_loss_cnt), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int seen[$];
        logic [1:0] last_rc;

        model_reset();
        #1 sys_rst_n = 1'b0;
        #2 chk_reset_vals("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Lock arrives at cycle 10; idelay pulse length and hold length.
        repeat (9) tick();
        sys_clk_lock = 1'b1;
        run_until(1, 10, "reach_idly_rst");
        n = 0;
        while (state === 3'd1 && n < 100) begin tick(); n++; end
        chk("idly_rst_len", n, RP);
        chk("idelay_rst_fell", 32'(idelay_rst), 0);
        repeat (5) tick();
        idelay_rdy = 1'b1;
        run_until(3, 10, "reach_hold");
        n = 0;
        while (state === 3'd3 && n < 100) begin tick(); n++; end
        chk("hold_len", n, HC);
        chk("ready_in_run", 32'(ready), 1);
        repeat (4) tick();

        // Three lock losses while running.
        for (int i = 0; i < 3; i++) begin
            sys_clk_lock = 1'b0;
            n = 0;
            while (sys_rst !== 1'b1 && n < 3) begin tick(); n++; end
            chk("sys_rst_after_drop", 32'(sys_rst), 1);
            chk("lock_loss_cnt", 32'(lock_loss_cnt), i + 1);
            repeat ($urandom_range(1, 5)) tick();
            sys_clk_lock = 1'b1;
            run_until(1, 10, "reseq_idly_rst");
            run_until(4, 200, "reseq_run");
        end

        // idelay_rdy never returns: retries then FAULT.
        idelay_rdy = 1'b0;
        last_rc = retry_cnt;
        n = 0;
        while (state !== 3'd5 && n < 2000) begin
            tick();
            n++;
            if (retry_cnt !== last_rc) begin
                seen.push_back(int'(retry_cnt));
                last_rc = retry_cnt;
            end
        end
        chk("retry_seq_len", seen.size(), 3);
        for (int i = 0; i < seen.size() && i < 3; i++) chk("retry_seq", seen[i], i + 1);
        chk("fault_state", 32'(state), 5);
        chk("fault_flag", 32'(fault), 1);
        chk("fault_sys_rst", 32'(sys_rst), 1);
        repeat ($urandom_range(3, 10)) tick();
        chk("fault_sticky", 32'(state), 5);

        // Software restart out of FAULT.
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        chk("soft_state", 32'(state), 0);
        chk("soft_retry", 32'(retry_cnt), 0);
        chk("soft_fault", 32'(fault), 0);
        chk("soft_llc", 32'(lock_loss_cnt), 3);
        idelay_rdy = 1'b1;
        run_until(4, 300, "soft_to_run");

        // One genuine rdy timeout, then lock loss landing on the timeout cycle.
        idelay_rdy = 1'b0;
        run_until(2, 50, "wait_rdy_a");
        run_until(0, 200, "rdy_timeout");
        chk("retry_after_timeout", 32'(retry_cnt), 1);
        run_until(2, 50, "wait_rdy_b");
        n = 0;
        while (m_el != RT - 3 && n < 200) begin tick(); n++; end
        sys_clk_lock = 1'b0;
        repeat (3) tick();
        chk("coincident_state", 32'(state), 0);
        chk("coincident_retry", 32'(retry_cnt), 1);
        sys_clk_lock = 1'b1;
        idelay_rdy = 1'b1;
        run_until(4, 300, "recover_run");
        chk("run_clears_retry", 32'(retry_cnt), 0);

        // Asynchronous reset in the middle of HOLD.
        idelay_rdy = 1'b0;
        run_until(1, 10, "rdy_drop_idly");
        idelay_rdy = 1'b1;
        run_until(3, 100, "hold_again");
        repeat (5) tick();
        #2 sys_rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        model_reset();
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk_reset_vals("in_rst");
        sys_rst_n = 1'b1;
        run_until(4, 200, "post_rst_run");

        // Randomized lock/rdy activity with occasional restarts.
        repeat (4000) begin
            if ($urandom_range(0, 199) == 0) sys_clk_lock = ~sys_clk_lock;
            if ($urandom_range(0, 149) == 0) idelay_rdy = ~idelay_rdy;
            soft_rst_req = ($urandom_range(0, 599) == 0);
            tick();
        end
        soft_rst_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
